stage_id_pipe: RTL

STAGE_ID_PIPE -- requirements
Module: stage_id_pipe

---
 rtl/noname_pkg.sv | 82 ++++++++
 rtl/id_fwd_select.sv | 22 ++
 rtl/stage_id_pipe.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/noname_pkg.sv
// noname_pkg: opcodes, instruction classes, operand selects and decode helpers for stage_id_pipe
package noname_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_OP       = 4'd0,
        CLS_OP_IMM   = 4'd1,
        CLS_LUI      = 4'd2,
        CLS_AUIPC    = 4'd3,
        CLS_JAL      = 4'd4,
        CLS_JALR     = 4'd5,
        CLS_BRANCH   = 4'd6,
        CLS_LOAD     = 4'd7,
        CLS_STORE    = 4'd8,
        CLS_MISC_MEM = 4'd9,
        CLS_SYSTEM   = 4'd10,
        CLS_ILLEGAL  = 4'd15
    } op_class_e;

    typedef enum logic [1:0] {SEL_REG, SEL_IMM, SEL_PC, SEL_ZERO} opsel_e;

    // The word-sized RV64 ops share the OP/OP_IMM datapath and are illegal on RV32.
    function automatic op_class_e decode_class(input logic [31:0] inst, input logic rv64);
        case (inst[6:0])
            OPC_OP:        return CLS_OP;
            OPC_OP_IMM:    return CLS_OP_IMM;
            OPC_OP_32:     return rv64 ? CLS_OP : CLS_ILLEGAL;
            OPC_OP_IMM_32: return rv64 ? CLS_OP_IMM : CLS_ILLEGAL;
            OPC_LUI:       return CLS_LUI;
            OPC_AUIPC:     return CLS_AUIPC;
            OPC_JAL:       return CLS_JAL;
            OPC_JALR:      return CLS_JALR;
            OPC_BRANCH:    return CLS_BRANCH;
            OPC_LOAD:      return CLS_LOAD;
            OPC_STORE:     return CLS_STORE;
            OPC_MISC_MEM:  return CLS_MISC_MEM;
            OPC_SYSTEM:    return CLS_SYSTEM;
            default:       return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [31:0] gen_imm(input logic [31:0] i, input op_class_e cls);
        case (cls)
            CLS_OP_IMM, CLS_LOAD, CLS_JALR, CLS_SYSTEM: return {{20{i[31]}}, i[31:20]};
            CLS_STORE:            return {{20{i[31]}}, i[31:25], i[11:7]};
            CLS_BRANCH:           return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            CLS_LUI, CLS_AUIPC:   return {i[31:12], 12'b0};
            CLS_JAL:              return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:              return '0;
        endcase
    endfunction

    function automatic opsel_e sel_a(input op_class_e cls);
        case (cls)
            CLS_OP, CLS_BRANCH, CLS_OP_IMM, CLS_LOAD, CLS_STORE, CLS_JALR, CLS_SYSTEM: return SEL_REG;
            CLS_AUIPC, CLS_JAL: return SEL_PC;
            default:            return SEL_ZERO;
        endcase
    endfunction

    function automatic opsel_e sel_b(input op_class_e cls);
        case (cls)
            CLS_OP, CLS_BRANCH: return SEL_REG;
            CLS_OP_IMM, CLS_LOAD, CLS_STORE, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_JAL: return SEL_IMM;
            default:            return SEL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/id_fwd_select.sv
// id_fwd_select: resolves one source operand from forwarding sources (index 0 wins) or register file data
module id_fwd_select #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic [4:0]              rs_i,
    input  logic [NUM_FWD-1:0]      fwd_valid_i,
    input  logic [5*NUM_FWD-1:0]    fwd_rd_i,
    input  logic [XLEN*NUM_FWD-1:0] fwd_dat_i,
    input  logic [XLEN-1:0]         rf_dat_i,
    output logic [XLEN-1:0]         dat_o
);

    // Walk from lowest priority up so the lowest matching index is written last.
    always_comb begin
        dat_o = rf_dat_i;
        for (int i = NUM_FWD - 1; i >= 0; i--)
            if (fwd_valid_i[i] && fwd_rd_i[5*i +: 5] == rs_i) dat_o = fwd_dat_i[XLEN*i +: XLEN];
        if (rs_i == 5'd0) dat_o = '0;
    end

endmodule

// File: rtl/stage_id_pipe.sv
// stage_id_pipe: RV32I/RV64I decode stage with register file, forwarding, load-use stall and ID/EX register.
// Define STAGE_ID_RF_BYPASS_EN to make a same-cycle write-back visible to register file reads.
module stage_id_pipe
    import noname_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic [31:0]             instruction_i,
    input  logic [XLEN-1:0]         pc_i,
    output logic                    ready_o,
    input  logic                    rf_we_i,
    input  logic [4:0]              rf_rd_i,
    input  logic [XLEN-1:0]         rf_wd_i,
    input  logic [NUM_FWD-1:0]      fwd_valid_i,
    input  logic [5*NUM_FWD-1:0]    fwd_rd_i,
    input  logic [XLEN*NUM_FWD-1:0] fwd_dat_i,
    input  logic                    ex_is_load_i,
    input  logic [4:0]              ex_rd_i,
    input  logic                    flush_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [XLEN-1:0]         pc_o,
    output logic [4:0]              rs1_o,
    output logic [4:0]              rs2_o,
    output logic [4:0]              rd_o,
    output logic [2:0]              funct3_o,
    output logic [XLEN-1:0]         dat_a_o,
    output logic [XLEN-1:0]         dat_b_o,
    output logic [XLEN-1:0]         imm_o,
    output logic [3:0]              op_class_o,
    output logic                    e_illegal_inst_o
);

    op_class_e       cls;
    opsel_e          sa, sb;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] imm, rf_a, rf_b, fwd_a, fwd_b, opnd_a, opnd_b;
    logic            uses_rs2, stall, accept;
    logic [XLEN-1:0] rf_q [1:31];
    logic [XLEN-1:0] rf_d [1:31];

    logic            valid_q, valid_d, illegal_q, illegal_d;
    logic [XLEN-1:0] pc_q, pc_d, dat_a_q, dat_a_d, dat_b_q, dat_b_d, imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [3:0]      op_class_q, op_class_d;

    assign cls      = decode_class(instruction_i, XLEN == 64);
    assign sa       = sel_a(cls);
    assign sb       = sel_b(cls);
    assign rs1      = instruction_i[19:15];
    assign rs2      = instruction_i[24:20];
    assign imm      = XLEN'($signed(gen_imm(instruction_i, cls)));
    assign uses_rs2 = cls == CLS_OP || cls == CLS_BRANCH || cls == CLS_STORE;

    assign stall   = valid_i && ex_is_load_i && ex_rd_i != 5'd0 &&
                     ((sa == SEL_REG && ex_rd_i == rs1) || (uses_rs2 && ex_rd_i == rs2));
    assign ready_o = !stall && (!valid_q || ready_i);
    assign accept  = valid_i && ready_o;

    always_comb begin
        rf_d = rf_q;
        if (rf_we_i && rf_rd_i != 5'd0) rf_d[rf_rd_i] = rf_wd_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rf_q <= '{default: '0};
        else       rf_q <= rf_d;
    end

`ifdef STAGE_ID_RF_BYPASS_EN
    assign rf_a = rs1 == 5'd0 ? '0 : (rf_we_i && rf_rd_i == rs1) ? rf_wd_i : rf_q[rs1];
    assign rf_b = rs2 == 5'd0 ? '0 : (rf_we_i && rf_rd_i == rs2) ? rf_wd_i : rf_q[rs2];
`else
    assign rf_a = rs1 == 5'd0 ? '0 : rf_q[rs1];
    assign rf_b = rs2 == 5'd0 ? '0 : rf_q[rs2];
`endif

    id_fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_a (
        .rs_i(rs1), .fwd_valid_i(fwd_valid_i), .fwd_rd_i(fwd_rd_i),
        .fwd_dat_i(fwd_dat_i), .rf_dat_i(rf_a), .dat_o(fwd_a)
    );

    id_fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_b (
        .rs_i(rs2), .fwd_valid_i(fwd_valid_i), .fwd_rd_i(fwd_rd_i),
        .fwd_dat_i(fwd_dat_i), .rf_dat_i(rf_b), .dat_o(fwd_b)
    );

    assign opnd_a = sa == SEL_REG ? fwd_a : sa == SEL_PC ? pc_i : '0;
    assign opnd_b = sb == SEL_REG ? fwd_b : sb == SEL_IMM ? imm : '0;

    // Payload only reloads on accept; a bubble or flush just drops valid.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        dat_a_d    = dat_a_q;
        dat_b_d    = dat_b_q;
        imm_d      = imm_q;
        op_class_d = op_class_q;
        illegal_d  = illegal_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (!valid_q || ready_i) begin
            valid_d = accept;
            if (accept) begin
                pc_d       = pc_i;
                rs1_d      = rs1;
                rs2_d      = rs2;
                rd_d       = instruction_i[11:7];
                funct3_d   = instruction_i[14:12];
                dat_a_d    = opnd_a;
                dat_b_d    = opnd_b;
                imm_d      = imm;
                op_class_d = cls;
                illegal_d  = cls == CLS_ILLEGAL;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            dat_a_q    <= '0;
            dat_b_q    <= '0;
            imm_q      <= '0;
            op_class_q <= '0;
            illegal_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            dat_a_q    <= dat_a_d;
            dat_b_q    <= dat_b_d;
            imm_q      <= imm_d;
            op_class_q <= op_class_d;
            illegal_q  <= illegal_d;
        end
    end

    assign valid_o          = valid_q;
    assign pc_o             = pc_q;
    assign rs1_o            = rs1_q;
    assign rs2_o            = rs2_q;
    assign rd_o             = rd_q;
    assign funct3_o         = funct3_q;
    assign dat_a_o          = dat_a_q;
    assign dat_b_o          = dat_b_q;
    assign imm_o            = imm_q;
    assign op_class_o       = op_class_q;
    assign e_illegal_inst_o = illegal_q;

endmodule
